fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter MAX_KERNEL_SIZE, default 5, largest legal kernel edge.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, idle-input cycles before a fault is raised.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_in  in  1  single-cycle request to run one convolution job.
REQ-006 SHALL have port abort_in  in  1  synchronous job cancel.
REQ-007 SHALL have port du_ker_size_in  in  3  kernel edge K.
REQ-008 SHALL have port du_img_size_in  in  12  image edge N.
REQ-009 SHALL have port fu_kernel_valid_in  in  1  fetch unit reports the kernel is loaded.
REQ-010 SHALL have port fu_pixel_valid_in  in  1  fetch unit emitted one image pixel.
REQ-011 SHALL have port fu_window_valid_in  in  1  fetch unit presented one window to the PE array.
REQ-012 SHALL have port cu_ker_fetch_en_out  out  1  kernel fetch enable to the fetch unit.
REQ-013 SHALL have port cu_img_fetch_en_out  out  1  image fetch enable to the fetch unit.
REQ-014 SHALL have port busy_out  out  1  high in KER, IMG and DRAIN.
REQ-015 SHALL have port done_out  out  1  one-cycle completion pulse.
REQ-016 SHALL have port err_out  out  1  sticky fault flag.
REQ-017 SHALL have port win_count_out  out  24  windows counted in the current or last job.
REQ-018 SHALL have port state_out  out  3  encoding IDLE=0, KER=1, IMG=2, DRAIN=3, DONE=4, ERR=5.

Function
REQ-019 SHALL latch K and N on an accepted start; later input changes do not affect the running job.
- start is accepted only in IDLE, DONE or ERR.
- An accepted start clears err_out and win_count_out.
REQ-020 SHALL go to ERR on the cycle after start if K==0, K>MAX_KERNEL_SIZE or K>N, with both fetch enables held low; otherwise it SHALL go to KER.
REQ-021 In KER, SHALL assert cu_ker_fetch_en_out=1 (registered) and hold cu_img_fetch_en_out=0.
- First fu_kernel_valid_in=1 moves to IMG on the next cycle.
REQ-022 In IMG, SHALL assert cu_img_fetch_en_out=1 and cu_ker_fetch_en_out=0, and SHALL count fu_pixel_valid_in pulses in a 24-bit counter.
- The cycle in which the count reaches N*N moves to DRAIN.
- cu_img_fetch_en_out is low from that next cycle.
REQ-023 SHALL increment win_count_out on each fu_window_valid_in in IMG or DRAIN.
- Expected total W=(N-K+1)^2, computed in 24 bits.
- Pulses beyond W are ignored; the counter saturates at W.
REQ-024 In DRAIN, SHALL move to DONE in the cycle after win_count_out==W; if W is already reached in IMG, DRAIN lasts exactly one cycle.
REQ-025 In DONE, SHALL assert done_out=1 for exactly one cycle, then return to IDLE, unless start is accepted in that cycle, in which case it goes to KER or ERR.
REQ-026 SHALL run a watchdog counter in KER, IMG and DRAIN.
- Cleared by any of the three fu_*_valid_in inputs and on each state entry.
- Reaching TIMEOUT_CYCLES moves to ERR with fetch enables low.
REQ-027 In ERR, SHALL hold err_out=1, keep both enables low, and remain there until an accepted start.
REQ-028 abort_in=1 in any state SHALL force IDLE the next cycle, with enables low and counters cleared; err_out is unchanged.
- abort_in has priority over start_in and over every other transition.
REQ-029 fu_* inputs outside the states that use them SHALL be ignored.
REQ-030 A simultaneous fu_pixel_valid_in and fu_window_valid_in SHALL both be counted in the same cycle.

Reset
REQ-031 When rstn=0 at a rising edge, the block SHALL:
- enter IDLE;
- drive cu_ker_fetch_en_out=0, cu_img_fetch_en_out=0, busy_out=0, done_out=0, err_out=0, win_count_out=0 and state_out=0;
- clear all internal counters.
This applies mid-job as well; a held start_in is ignored while rstn=0.

Verification
REQ-032 Nominal: K=3, N=4, start. Expected: ker_en=1 until kernel_valid; then img_en=1 for 16 pixel pulses; 4 window pulses; one done_out pulse; win_count_out=4; return to IDLE.
REQ-033 Bad config: K=5, N=4, start. Expected: state ERR the next cycle, err_out=1, no enable ever asserted; then K=3, N=4, start clears err_out and the job runs.
REQ-034 Timeout: TIMEOUT_CYCLES=16, K=3, N=4, kernel_valid never arrives. Expected: ERR exactly 16 cycles after KER entry, ker_en drops.
REQ-035 Abort: abort_in at the 8th pixel in IMG, together with start_in. Expected: IDLE next cycle, img_en=0, win_count_out=0, start not accepted.
REQ-036 start_in pulsed during IMG is ignored; 6 window pulses with W=4 leave win_count_out=4; rstn=0 mid-DRAIN gives all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Control unit for one convolution job: kernel fetch, image fetch, and the
// drain of the remaining windows, with a watchdog and a sticky fault flag.
module fetch_sequencer #(
    parameter int MAX_KERNEL_SIZE = 5,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_in,
    input  logic        abort_in,
    input  logic [2:0]  du_ker_size_in,
    input  logic [11:0] du_img_size_in,
    input  logic        fu_kernel_valid_in,
    input  logic        fu_pixel_valid_in,
    input  logic        fu_window_valid_in,
    output logic        cu_ker_fetch_en_out,
    output logic        cu_img_fetch_en_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out,
    output logic [23:0] win_count_out,
    output logic [2:0]  state_out
);

    // state | meaning
    // IDLE  | waiting for start
    // KER   | kernel fetch enabled, waiting for kernel loaded
    // IMG   | image fetch enabled, counting pixels up to N*N
    // DRAIN | image fetched, waiting for the last windows
    // DONE  | one-cycle completion
    // ERR   | bad configuration or watchdog expiry, sticky until start
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KER   = 3'd1,
        IMG   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    // Watchdog must be able to hold TIMEOUT_CYCLES-1.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       ker_size;
    logic [11:0]      img_size;
    logic [23:0]      pix_cnt;
    logic [WD_W-1:0]  wd_cnt;

    logic [23:0]      img_side;
    logic [23:0]      win_side;
    logic [23:0]      img_total;
    logic [23:0]      win_total;
    logic             in_run;
    logic             any_valid;
    logic             start_ok;
    logic             cfg_ok;
    logic             pix_last;
    logic             win_full;
    logic             timeout;

    // Job totals come from the sizes latched at start, so later input
    // changes cannot disturb a running job. K <= N is guaranteed here.
    assign img_side  = {12'd0, img_size};
    assign win_side  = img_side - {21'd0, ker_size} + 24'd1;
    assign img_total = img_side * img_side;
    assign win_total = win_side * win_side;

    assign in_run    = (state == KER) || (state == IMG) || (state == DRAIN);
    assign any_valid = fu_kernel_valid_in || fu_pixel_valid_in || fu_window_valid_in;
    assign start_ok  = start_in && !abort_in &&
                       ((state == IDLE) || (state == DONE) || (state == ERR));
    assign cfg_ok    = (du_ker_size_in != 3'd0) &&
                       ({29'd0, du_ker_size_in} <= 32'(MAX_KERNEL_SIZE)) &&
                       ({9'd0, du_ker_size_in} <= du_img_size_in);
    assign pix_last  = fu_pixel_valid_in && ((pix_cnt + 24'd1) == img_total);
    assign win_full  = (win_count_out == win_total);
    assign timeout   = !any_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign state_out = state;

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (abort_in) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_in) begin
                        state_nxt = cfg_ok ? KER : ERR;
                    end else if (state == DONE) begin
                        state_nxt = IDLE;
                    end
                end
                KER: begin
                    if (fu_kernel_valid_in) state_nxt = IMG;
                    else if (timeout)       state_nxt = ERR;
                end
                IMG: begin
                    if (pix_last)     state_nxt = DRAIN;
                    else if (timeout) state_nxt = ERR;
                end
                DRAIN: begin
                    if (win_full)     state_nxt = DONE;
                    else if (timeout) state_nxt = ERR;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, registered outputs decoded from the next state, and job counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state               <= IDLE;
            cu_ker_fetch_en_out <= 1'b0;
            cu_img_fetch_en_out <= 1'b0;
            busy_out            <= 1'b0;
            done_out            <= 1'b0;
            err_out             <= 1'b0;
            win_count_out       <= 24'd0;
            pix_cnt             <= 24'd0;
            wd_cnt              <= '0;
            ker_size            <= 3'd0;
            img_size            <= 12'd0;
        end else begin
            state               <= state_nxt;
            cu_ker_fetch_en_out <= (state_nxt == KER);
            cu_img_fetch_en_out <= (state_nxt == IMG);
            busy_out            <= (state_nxt == KER) || (state_nxt == IMG) ||
                                   (state_nxt == DRAIN);
            done_out            <= (state_nxt == DONE);

            if (!abort_in) begin
                if (state_nxt == ERR) err_out <= 1'b1;
                else if (start_ok)    err_out <= 1'b0;
            end

            if (abort_in) begin
                win_count_out <= 24'd0;
                pix_cnt       <= 24'd0;
                wd_cnt        <= '0;
            end else if (start_ok) begin
                ker_size      <= du_ker_size_in;
                img_size      <= du_img_size_in;
                win_count_out <= 24'd0;
                pix_cnt       <= 24'd0;
                wd_cnt        <= '0;
            end else begin
                if ((state == IMG) && fu_pixel_valid_in) begin
                    pix_cnt <= pix_cnt + 24'd1;
                end
                if (((state == IMG) || (state == DRAIN)) && fu_window_valid_in && !win_full) begin
                    win_count_out <= win_count_out + 24'd1;
                end
                if (!in_run || any_valid || (state_nxt != state)) begin
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a job-level reference model checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_fetch_sequencer;

    localparam int MAXK = 5;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_in;
    logic        abort_in;
    logic [2:0]  du_ker_size_in;
    logic [11:0] du_img_size_in;
    logic        fu_kernel_valid_in;
    logic        fu_pixel_valid_in;
    logic        fu_window_valid_in;
    logic        cu_ker_fetch_en_out;
    logic        cu_img_fetch_en_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
    logic [23:0] win_count_out;
    logic [2:0]  state_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    fetch_sequencer #(.MAX_KERNEL_SIZE(MAXK), .TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .start_in            (start_in),
        .abort_in            (abort_in),
        .du_ker_size_in      (du_ker_size_in),
        .du_img_size_in      (du_img_size_in),
        .fu_kernel_valid_in  (fu_kernel_valid_in),
        .fu_pixel_valid_in   (fu_pixel_valid_in),
        .fu_window_valid_in  (fu_window_valid_in),
        .cu_ker_fetch_en_out (cu_ker_fetch_en_out),
        .cu_img_fetch_en_out (cu_img_fetch_en_out),
        .busy_out            (busy_out),
        .done_out            (done_out),
        .err_out             (err_out),
        .win_count_out       (win_count_out),
        .state_out           (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase numbers follow the published state encoding,
    // counts are plain integers derived from the job's K and N.
    int m_phase = 0, m_k = 0, m_n = 0, m_pix = 0, m_win = 0, m_idle = 0, m_err = 0;
    int m_prev;
    bit m_any;

    function automatic int m_wtot();
        return (m_n - m_k + 1) * (m_n - m_k + 1);
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_phase = 0; m_pix = 0; m_win = 0; m_idle = 0; m_err = 0;
        end else if (abort_in) begin
            m_phase = 0; m_pix = 0; m_win = 0; m_idle = 0;
        end else begin
            m_prev = m_phase;
            m_any  = fu_kernel_valid_in | fu_pixel_valid_in | fu_window_valid_in;
            case (m_phase)
                0, 4, 5: begin
                    if (start_in) begin
                        m_k = int'(du_ker_size_in);
                        m_n = int'(du_img_size_in);
                        m_pix = 0; m_win = 0; m_err = 0;
                        m_phase = (m_k == 0 || m_k > MAXK || m_k > m_n) ? 5 : 1;
                    end else if (m_phase == 4) begin
                        m_phase = 0;
                    end
                end
                1: begin
                    if (fu_kernel_valid_in) m_phase = 2;
                    else if (!m_any && m_idle + 1 == TO) m_phase = 5;
                end
                2: begin
                    if (fu_window_valid_in && m_win < m_wtot()) m_win++;
                    if (fu_pixel_valid_in) begin
                        m_pix++;
                        if (m_pix == m_n * m_n) m_phase = 3;
                    end else if (!m_any && m_idle + 1 == TO) m_phase = 5;
                end
                3: begin
                    if (m_win == m_wtot()) m_phase = 4;
                    else if (!m_any && m_idle + 1 == TO) m_phase = 5;
                    if (fu_window_valid_in && m_win < m_wtot()) m_win++;
                end
                default: m_phase = 0;
            endcase
            if (m_phase >= 1 && m_phase <= 3 && m_phase == m_prev && !m_any) m_idle++;
            else m_idle = 0;
            if (m_phase == 5) m_err = 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("state",   32'(state_out),           32'(m_phase));
            check("ker_en",  32'(cu_ker_fetch_en_out), 32'(m_phase == 1));
            check("img_en",  32'(cu_img_fetch_en_out), 32'(m_phase == 2));
            check("busy",    32'(busy_out),            32'(m_phase >= 1 && m_phase <= 3));
            check("done",    32'(done_out),            32'(m_phase == 4));
            check("err",     32'(err_out),             32'(m_err));
            check("win_cnt", 32'(win_count_out),       32'(m_win));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k, input int n);
        du_ker_size_in = 3'(k);
        du_img_size_in = 12'(n);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    int cnt;

    initial begin
        rstn = 1'b0; start_in = 1'b0; abort_in = 1'b0;
        du_ker_size_in = 3'd0; du_img_size_in = 12'd0;
        fu_kernel_valid_in = 1'b0; fu_pixel_valid_in = 1'b0; fu_window_valid_in = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        check("rst_state", 32'(state_out), 0);
        check("rst_win", 32'(win_count_out), 0);
        rstn = 1'b1;
        step();

        // Nominal K=3 N=4: 16 pixels, 4 windows, one done pulse.
        start_job(3, 4);
        check("nom_ker_en", 32'(cu_ker_fetch_en_out), 1);
        du_ker_size_in = 3'd7; du_img_size_in = 12'd2;
        step();
        fu_pixel_valid_in = 1'b1; fu_window_valid_in = 1'b1;
        step();
        fu_pixel_valid_in = 1'b0; fu_window_valid_in = 1'b0;
        check("nom_ker_ignore_fu", 32'(state_out), 1);
        fu_kernel_valid_in = 1'b1;
        step();
        fu_kernel_valid_in = 1'b0;
        check("nom_img_state", 32'(state_out), 2);
        for (int i = 1; i <= 16; i++) begin
            fu_pixel_valid_in = 1'b1;
            fu_window_valid_in = (i >= 13);
            step();
        end
        fu_pixel_valid_in = 1'b0; fu_window_valid_in = 1'b0;
        check("nom_drain", 32'(state_out), 3);
        check("nom_win4", 32'(win_count_out), 4);
        check("nom_img_off", 32'(cu_img_fetch_en_out), 0);
        step();
        check("nom_done", 32'(done_out), 1);
        step();
        check("nom_idle", 32'(state_out), 0);
        check("nom_done_one", 32'(done_out), 0);
        check("nom_win_kept", 32'(win_count_out), 4);

        // Bad configuration, then recovery.
        start_job(5, 4);
        check("bad_state", 32'(state_out), 5);
        check("bad_err", 32'(err_out), 1);
        check("bad_ker_en", 32'(cu_ker_fetch_en_out), 0);
        step();
        step();
        start_job(3, 4);
        check("rec_err_clr", 32'(err_out), 0);
        check("rec_state", 32'(state_out), 1);
        fu_kernel_valid_in = 1'b1;
        step();
        fu_kernel_valid_in = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            fu_pixel_valid_in = 1'b1;
            fu_window_valid_in = (i == 3 || i == 9);
            start_in = (i == 8);
            step();
        end
        start_in = 1'b0; fu_pixel_valid_in = 1'b0;
        check("rec_drain", 32'(state_out), 3);
        check("rec_win2", 32'(win_count_out), 2);
        fu_window_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        fu_window_valid_in = 1'b0;
        check("rec_sat", 32'(win_count_out), 4);
        check("rec_idle", 32'(state_out), 0);

        // Reset in the middle of DRAIN with start held.
        start_job(2, 3);
        fu_kernel_valid_in = 1'b1;
        step();
        fu_kernel_valid_in = 1'b0;
        fu_pixel_valid_in = 1'b1;
        for (int i = 0; i < 9; i++) step();
        fu_pixel_valid_in = 1'b0;
        check("rst_drain_pre", 32'(state_out), 3);
        step();
        rstn = 1'b0; start_in = 1'b1;
        step();
        check("rst_mid_state", 32'(state_out), 0);
        check("rst_mid_busy", 32'(busy_out), 0);
        step();
        check("rst_mid_start", 32'(state_out), 0);
        rstn = 1'b1; start_in = 1'b0;
        step();

        // Watchdog in KER.
        start_job(3, 4);
        cnt = 0;
        while (state_out != 3'd5 && cnt < 40) begin
            step();
            cnt++;
        end
        check("to_cycles", 32'(cnt), 16);
        check("to_ker_en", 32'(cu_ker_fetch_en_out), 0);
        check("to_err", 32'(err_out), 1);

        // Abort at the 8th pixel together with start.
        start_job(3, 4);
        fu_kernel_valid_in = 1'b1;
        step();
        fu_kernel_valid_in = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            fu_pixel_valid_in = 1'b1;
            fu_window_valid_in = (i == 5);
            step();
        end
        fu_window_valid_in = 1'b0;
        abort_in = 1'b1; start_in = 1'b1;
        step();
        abort_in = 1'b0; start_in = 1'b0; fu_pixel_valid_in = 1'b0;
        check("ab_state", 32'(state_out), 0);
        check("ab_img_en", 32'(cu_img_fetch_en_out), 0);
        check("ab_win", 32'(win_count_out), 0);
        step();
        check("ab_no_start", 32'(state_out), 0);

        // Abort leaves the fault flag alone.
        start_job(0, 4);
        check("k0_err", 32'(err_out), 1);
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        check("ab_err_kept", 32'(err_out), 1);
        check("ab_err_state", 32'(state_out), 0);

        // Fetch-unit pulses in IDLE are ignored.
        fu_kernel_valid_in = 1'b1; fu_pixel_valid_in = 1'b1; fu_window_valid_in = 1'b1;
        step();
        fu_kernel_valid_in = 1'b0; fu_pixel_valid_in = 1'b0; fu_window_valid_in = 1'b0;
        check("idle_ignore", 32'(state_out), 0);

        // K=N=1, then a start accepted in the DONE cycle.
        start_job(1, 1);
        fu_kernel_valid_in = 1'b1;
        step();
        fu_kernel_valid_in = 1'b0;
        fu_pixel_valid_in = 1'b1; fu_window_valid_in = 1'b1;
        step();
        fu_pixel_valid_in = 1'b0; fu_window_valid_in = 1'b0;
        check("k1_drain_win", 32'(win_count_out), 1);
        step();
        check("k1_done", 32'(done_out), 1);
        start_job(1, 2);
        check("done_restart", 32'(state_out), 1);
        check("done_restart_win", 32'(win_count_out), 0);
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
